seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 117 +++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: issues a fetch strobe per digit slot,
// latches the returned character a fixed latency later and drives active-low anodes/segments.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100_000,
    parameter int FETCH_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] char_in,
    input  logic [3:0] dp_in,
    input  logic       blank,
    output logic [1:0] refresh,
    output logic       ref_sign,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LATCH = CW'(FETCH_LAT);

    typedef enum logic [1:0] {
        PH_REQ,
        PH_WAIT,
        PH_LATCH,
        PH_SHOW
    } phase_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_refresh;
    logic          r_refSign;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    phase_t        w_phase;
    logic [3:0]    w_anLit;
    logic [6:0]    w_segCode;

    function automatic logic [6:0] decodeChar(input logic [5:0] code);
        logic [6:0] s;
        case (code)
            6'd0:    s = 7'h40;
            6'd1:    s = 7'h79;
            6'd2:    s = 7'h24;
            6'd3:    s = 7'h30;
            6'd4:    s = 7'h19;
            6'd5:    s = 7'h12;
            6'd6:    s = 7'h02;
            6'd7:    s = 7'h78;
            6'd8:    s = 7'h00;
            6'd9:    s = 7'h10;
            6'd10:   s = 7'h08;
            6'd11:   s = 7'h03;
            6'd12:   s = 7'h46;
            6'd13:   s = 7'h21;
            6'd14:   s = 7'h06;
            6'd15:   s = 7'h0E;
            6'd21:   s = 7'h47;
            6'd22:   s = 7'h48;
            6'd24:   s = 7'h40;
            6'd32:   s = 7'h41;
            6'd36:   s = 7'h7F;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        w_phase = PH_SHOW;
        if (r_cnt == '0) begin
            w_phase = PH_REQ;
        end else if (r_cnt < CNT_LATCH) begin
            w_phase = PH_WAIT;
        end else if (r_cnt == CNT_LATCH) begin
            w_phase = PH_LATCH;
        end
    end

    assign w_anLit   = blank ? 4'b1111 : ~(4'b0001 << r_refresh);
    assign w_segCode = decodeChar(char_in);

    // The slot wrap always blanks the anodes, so the next fetch window starts dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= CNT_LAST;
            r_refresh <= 2'd3;
            r_refSign <= 1'b0;
            r_an      <= 4'b1111;
            r_seg     <= 8'hFF;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_refresh <= r_refresh + 2'd1;
            r_refSign <= 1'b1;
            r_an      <= 4'b1111;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_refSign <= 1'b0;
            case (w_phase)
                PH_LATCH: begin
                    r_seg <= {~dp_in[r_refresh], w_segCode};
                    r_an  <= w_anLit;
                end
                PH_SHOW: begin
                    r_an <= w_anLit;
                end
                default: begin
                end
            endcase
        end
    end

    assign refresh  = r_refresh;
    assign ref_sign = r_refSign;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule
